// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults, counter-width helper, button indices and level state type
package debounce_pkg;
  localparam int STABLE_CYCLES_DEF = 1000000;
  localparam int TICK_DIV_DEF = 1000;
  localparam int BTN_UP = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_LEFT = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_CENTER = 4;
  typedef enum logic {LOW = 1'b0, HIGH = 1'b1} level_t;
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: two-flop synchroniser, stability counter and debounced level for one button
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int LIMIT = STABLE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic busy
);
  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  logic sync1, sync2, match, done;
  logic [CW-1:0] cnt, cnt_nxt;
  level_t state, state_nxt;
  assign level = state;
  // synchroniser, counter, level and busy registers; reset discards any partial count
  always_ff @(posedge clock)
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt <= '0;
      state <= LOW;
      busy <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt <= cnt_nxt;
      state <= state_nxt;
      busy <= cnt_nxt != '0;
    end
  // a matching sample clears the count; a mismatch advances it on ticks and flips the level at the threshold
  always_comb begin
    match = sync2 == logic'(state);
    done = !match && tick && cnt == LAST;
    cnt_nxt = (match || done) ? '0 : tick ? cnt + CW'(1) : cnt;
    state_nxt = done ? level_t'(sync2) : state;
  end
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: N_BTN independent debouncers; DEBOUNCE_TICK_PRESCALE_EN adds a shared sample-tick divider
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_busy
);
  logic tick;
`ifdef DEBOUNCE_TICK_PRESCALE_EN
  localparam int LIMIT = STABLE_CYCLES / TICK_DIV;
  localparam int DW = cnt_width(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  logic [DW-1:0] div;
  // free-running divider; the tick is seen by the channels on edges TICK_DIV, 2*TICK_DIV, ... after reset
  always_ff @(posedge clock)
    if (!reset_n) div <= '0;
    else div <= (div == DIV_LAST) ? '0 : div + DW'(1);
  assign tick = div == DIV_LAST;
`else
  localparam int LIMIT = STABLE_CYCLES;
  assign tick = 1'b1;
`endif
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(.LIMIT(LIMIT)) u_ch (
      .clock(clock),
      .reset_n(reset_n),
      .tick(tick),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .busy(btn_busy[i])
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed checks of reset, latency, bounce, mid-count reset and simultaneous channels
module tb_button_debouncer;
  logic clock = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic [4:0] raw_a, raw_b, raw_c;
  logic [4:0] level_a, busy_a, level_b, busy_b, level_c, busy_c;
  int checks = 0;
  int failures = 0;
  always #5 clock = ~clock;
  button_debouncer #(.N_BTN(5), .STABLE_CYCLES(4), .TICK_DIV(1)) dut_a (
    .clock(clock), .reset_n(rst_a), .btn_raw(raw_a), .btn_level(level_a), .btn_busy(busy_a)
  );
  button_debouncer #(.N_BTN(5), .STABLE_CYCLES(3), .TICK_DIV(1)) dut_b (
    .clock(clock), .reset_n(rst_b), .btn_raw(raw_b), .btn_level(level_b), .btn_busy(busy_b)
  );
`ifdef DEBOUNCE_TICK_PRESCALE_EN
  button_debouncer #(.N_BTN(5), .STABLE_CYCLES(8), .TICK_DIV(4)) dut_c (
    .clock(clock), .reset_n(rst_c), .btn_raw(raw_c), .btn_level(level_c), .btn_busy(busy_c)
  );
`else
  assign level_c = '0;
  assign busy_c = '0;
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    raw_a = 5'b11111;
    raw_b = '0;
    raw_c = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_level", level_a, 0);
      chk("rst_busy", busy_a, 0);
    end
    rst_a = 1'b1;
    step(5);
    chk("rel_hold", level_a, 0);
    chk("rel_busy", busy_a, 5'h1f);
    step();
    chk("rel_flip", level_a, 5'h1f);
    chk("rel_busy0", busy_a, 0);
    raw_a = '0;
    step(6);
    chk("all_low", level_a, 0);
    raw_a = 5'b00001;
    step(5);
    chk("press_hold", level_a, 0);
    step();
    chk("press_flip", level_a, 5'b00001);
    step(3);
    raw_a = '0;
    step(5);
    chk("release_hold", level_a, 5'b00001);
    step();
    chk("release_flip", level_a, 0);
    for (int p = 0; p < 5; p++) begin
      raw_a[2] = (p % 2 == 0);
      step();
      if (p > 0) chk("bounce_busy", busy_a[2], (p % 2 == 0) ? 0 : 1);
      chk("bounce_level", level_a, 0);
      if (p < 4) begin
        step();
        chk("bounce_level", level_a, 0);
      end
    end
    step(4);
    chk("bounce_hold", level_a, 0);
    step();
    chk("bounce_flip", level_a, 5'b00100);
    raw_a = 5'b00110;
    step(4);
    chk("mid_busy", busy_a[1], 1);
    chk("mid_level", level_a, 5'b00100);
    rst_a = 1'b0;
    step();
    chk("mid_rst_level", level_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    rst_a = 1'b1;
    step(5);
    chk("mid_hold", level_a, 0);
    step();
    chk("mid_flip", level_a, 5'b00110);
    rst_b = 1'b1;
    step(2);
    raw_b = 5'b10001;
    step();
    raw_b = 5'b11001;
    step(3);
    chk("sim_hold", level_b, 0);
    step();
    chk("sim_first", level_b, 5'b10001);
    step();
    chk("sim_second", level_b, 5'b11001);
`ifdef DEBOUNCE_TICK_PRESCALE_EN
    rst_c = 1'b1;
    step(4);
    raw_c = 5'b00001;
    step(7);
    chk("tick_hold", level_c, 0);
    step();
    chk("tick_flip", level_c, 5'b00001);
    raw_c = '0;
    step(4);
    chk("tick_busy", busy_c, 5'b00001);
    raw_c = 5'b00001;
    step();
    raw_c = '0;
    step(2);
    chk("glitch_clear", busy_c, 0);
    chk("glitch_level", level_c, 5'b00001);
    step();
    chk("glitch_recount", busy_c, 5'b00001);
    step(3);
    chk("glitch_hold", level_c, 5'b00001);
    step();
    chk("glitch_flip", level_c, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
